reg_mem_responder: RTL and testbench

//  Register-interface responder terminating a reg_intf req/rsp link in a word-addressed flop memory.

---
 rtl/reg_mem_responder.sv | 136 +++++++++++++
 tb/tb_reg_mem_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reg_mem_responder.sv
// reg_intf scratch register bank in a flop array; ready arrives WaitCycles cycles after valid, initiator holds req until ready.
// Build macro REG_MEM_RESPONDER_EMPTY_WR_ERR_EN: a hit write with every strobe low completes with error=1.
package reg_mem_responder_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } rsp_t;
endpackage

module reg_mem_responder #(
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          NumWords   = 16,
    parameter logic [AddrWidth-1:0] BaseAddr   = '0,
    parameter int unsigned          WaitCycles = 1,
    parameter type                  req_t      = reg_mem_responder_pkg::req_t,
    parameter type                  rsp_t      = reg_mem_responder_pkg::rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t req_i,
    output rsp_t rsp_o,
    output logic busy_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffBits   = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned CntWidth  = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;

    typedef enum logic {IDLE, WAIT} state_e;

    state_e               state;
    logic [CntWidth-1:0]  cnt;
    logic [DataWidth-1:0] mem [NumWords];

    logic [AddrWidth-1:0] off;
    logic [AddrWidth-1:0] idx_full;
    logic [IdxWidth-1:0]  idx;
    logic                 hit;
    logic                 ready;
    logic                 done;
    logic                 wr_en;
    logic                 err_resp;

    always_comb begin
        off      = req_i.addr - BaseAddr;
        idx_full = off >> OffBits;
        idx      = idx_full[IdxWidth-1:0];
        hit      = (req_i.addr >= BaseAddr)
                && (idx_full < AddrWidth'(NumWords))
                && ((off & AddrWidth'(StrbWidth - 1)) == '0);
    end

    // Ready is gated by valid so an aborted wait never produces a handshake.
    always_comb begin
        if (state == IDLE) begin
            ready = req_i.valid && (WaitCycles == 0);
        end else begin
            ready = req_i.valid && (cnt == '0);
        end
    end

    assign done  = req_i.valid && ready;
    assign wr_en = done && req_i.write && hit;

`ifdef REG_MEM_RESPONDER_EMPTY_WR_ERR_EN
    assign err_resp = !hit || (req_i.write && (req_i.wstrb == '0));
`else
    assign err_resp = !hit;
`endif

    always_comb begin
        rsp_o       = '0;
        rsp_o.ready = ready;
        if (done) begin
            rsp_o.error = err_resp;
            if (hit && !req_i.write) begin
                rsp_o.rdata = mem[idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i.valid && (WaitCycles != 0)) begin
                        state <= WAIT;
                        cnt   <= CntWidth'(WaitCycles - 1);
                    end
                end
                WAIT: begin
                    if (!req_i.valid || (cnt == '0)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CntWidth'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy_o = (state == WAIT);

    // An all-zero strobe naturally leaves the word untouched in both builds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumWords); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (req_i.wstrb[b]) begin
                    mem[idx][8*b +: 8] <= req_i.wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_mem_responder.sv
// Directed bench: three responders (WaitCycles 0, 1, 3) sharing clock and reset, checked with immediate assertions.
module tb_reg_mem_responder;
    import reg_mem_responder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef REG_MEM_RESPONDER_EMPTY_WR_ERR_EN
    localparam logic EMPTY_ERR = 1'b1;
`else
    localparam logic EMPTY_ERR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    req_t req0, req1, req3;
    rsp_t rsp0, rsp1, rsp3;
    logic busy0, busy1, busy3;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_mem_responder #(.BaseAddr(BASE), .WaitCycles(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .rsp_o(rsp0), .busy_o(busy0));
    reg_mem_responder #(.BaseAddr(BASE), .WaitCycles(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .rsp_o(rsp1), .busy_o(busy1));
    reg_mem_responder #(.BaseAddr(BASE), .WaitCycles(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .rsp_o(rsp3), .busy_o(busy3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        req_t q;
        q.addr  = addr;
        q.write = wr;
        q.wdata = wdata;
        q.wstrb = strb;
        q.valid = v;
        case (which)
            0:       req0 = q;
            1:       req1 = q;
            default: req3 = q;
        endcase
    endtask

    // which doubles as the instance's WaitCycles, i.e. the expected ready cycle index.
    task automatic xfer(input int which, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err, input string tag);
        rsp_t r;
        logic b;
        drive(which, 1'b1, wr, addr, wdata, strb);
        for (int c = 0; c <= which; c++) begin
            @(negedge clk);
            case (which)
                0:       begin r = rsp0; b = busy0; end
                1:       begin r = rsp1; b = busy1; end
                default: begin r = rsp3; b = busy3; end
            endcase
            chk({tag, ".ready"}, 32'(r.ready), 32'(c == which));
            chk({tag, ".busy"},  32'(b),       32'(c > 0));
            chk({tag, ".rdata"}, r.rdata,      (c == which) ? exp_rd : 32'h0);
            chk({tag, ".error"}, 32'(r.error), (c == which) ? 32'(exp_err) : 32'h0);
            @(posedge clk);
            #1;
        end
        drive(which, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(rsp1.ready), 32'h0);
        chk("rst.error", 32'(rsp1.error), 32'h0);
        chk("rst.rdata", rsp1.rdata, 32'h0);
        chk("rst.busy1", 32'(busy1), 32'h0);
        chk("rst.busy3", 32'(busy3), 32'h0);
        chk("rst.busy0", 32'(busy0), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(1, 1'b0, BASE, 32'h0, 4'h0, 32'h0, 1'b0, "t1_rd_base");

        xfer(1, 1'b1, BASE + 4, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, "t2_wr_full");
        xfer(1, 1'b1, BASE + 4, 32'h0000_0011, 4'b0001, 32'h0, 1'b0, "t2_wr_b0");
        xfer(1, 1'b0, BASE + 4, 32'h0, 4'h0, 32'hDEAD_BE11, 1'b0, "t2_rd_a");
        xfer(1, 1'b1, BASE + 4, 32'h77AA_5533, 4'b0110, 32'h0, 1'b0, "t2_wr_mid");
        xfer(1, 1'b0, BASE + 4, 32'h0, 4'h0, 32'hDEAA_5511, 1'b0, "t2_rd_b");

        xfer(1, 1'b0, BASE + 64, 32'h0, 4'h0, 32'h0, 1'b1, "t3_rd_range");
        xfer(1, 1'b0, BASE + 2, 32'h0, 4'h0, 32'h0, 1'b1, "t3_rd_misal");
        xfer(1, 1'b0, BASE - 4, 32'h0, 4'h0, 32'h0, 1'b1, "t3_rd_below");
        xfer(1, 1'b1, BASE + 64, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "t3_wr_range");
        xfer(1, 1'b1, BASE + 6, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "t3_wr_misal");
        xfer(1, 1'b0, BASE + 4, 32'h0, 4'h0, 32'hDEAA_5511, 1'b0, "t3_rd_keep");
        xfer(1, 1'b1, BASE + 60, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, "t3_wr_last");
        xfer(1, 1'b0, BASE + 60, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, "t3_rd_last");
        xfer(1, 1'b0, BASE, 32'h0, 4'h0, 32'h0, 1'b0, "t3_rd_w0");

        xfer(1, 1'b1, BASE, 32'h0102_0304, 4'hF, 32'h0, 1'b0, "t4_wr_init");
        xfer(1, 1'b1, BASE, 32'hFFFF_FFFF, 4'h0, 32'h0, EMPTY_ERR, "t4_wr_empty");
        xfer(1, 1'b0, BASE, 32'h0, 4'h0, 32'h0102_0304, 1'b0, "t4_rd_keep");

        xfer(3, 1'b1, BASE + 12, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "w3_wr");
        xfer(3, 1'b0, BASE + 12, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "w3_rd");
        drive(3, 1'b1, 1'b1, BASE + 8, 32'h1234_5678, 4'hF);
        @(posedge clk);
        #1;
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("w3_abort.busy_wait", 32'(busy3), 32'h1);
        chk("w3_abort.ready", 32'(rsp3.ready), 32'h0);
        @(negedge clk);
        chk("w3_abort.busy_idle", 32'(busy3), 32'h0);
        @(posedge clk);
        #1;
        xfer(3, 1'b0, BASE + 8, 32'h0, 4'h0, 32'h0, 1'b0, "w3_rd_abort");

        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b1, BASE + 32'(4 * i), 32'hA0B0_C0D0 ^ 32'(i), 4'hF, 32'h0, 1'b0, "t5_wr");
        end
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, 32'hA0B0_C0D0 ^ 32'(i), 1'b0, "t5_rd");
        end

        drive(1, 1'b1, 1'b1, BASE + 8, 32'h1234_5678, 4'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst.ready", 32'(rsp1.ready), 32'h0);
        chk("t6_rst.error", 32'(rsp1.error), 32'h0);
        chk("t6_rst.busy", 32'(busy1), 32'h0);
        @(negedge clk);
        chk("t6_rst.ready2", 32'(rsp1.ready), 32'h0);
        chk("t6_rst.busy2", 32'(busy1), 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(1, 1'b0, BASE + 8, 32'h0, 4'h0, 32'h0, 1'b0, "t6_rd_pending");
        xfer(1, 1'b0, BASE + 4, 32'h0, 4'h0, 32'h0, 1'b0, "t6_rd_cleared");
        xfer(0, 1'b0, BASE, 32'h0, 4'h0, 32'h0, 1'b0, "t6_rd_w0_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
